line_buffer_reader: RTL
=======================

Name: line_buffer_reader

Overview:
- Read-side controller for the 7-line FIFO line buffer.
- Monitors the per-line FIFO empty flags and pops one pixel from every line FIFO at once.
- Captures the FIFO outputs into an ordered 7-pixel column, oldest line first, and presents it downstream with a valid/ready handshake.
- Tracks the column position within an image line and rotates the line ordering at each end of line, so the window/filter stage always receives a vertically ordered column.

Parameters:
- D_BITS, 8, pixel width in bits.
- N_LINES, 7, number of line FIFOs read in parallel.
- IMG_WIDTH, 640, pixels per image line; must be ≥ 2.
- COL_W, $clog2(IMG_WIDTH), width of the column counter.

Ports:
- i_clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_enable  input  1  allows new pops when high.
- i_empty  input  N_LINES  per-line FIFO empty flags; bit k is FIFO k.
- i_dout  input  N_LINES*D_BITS  FIFO read data; FIFO k is at [k*D_BITS +: D_BITS]; valid 1 cycle after its rd_en.
- o_rd_en  output  N_LINES  FIFO read strobes; all bits are always equal.
- o_col  output  N_LINES*D_BITS  column; slot j is at [j*D_BITS +: D_BITS]; slot 0 is the oldest line.
- o_col_valid  output  1  o_col is valid.
- i_col_ready  input  1  downstream accepts the column.
- o_eol  output  1  the presented column is the last of its line; qualified by o_col_valid.
- o_top  output  $clog2(N_LINES)  index of the FIFO currently mapped to slot 0.

Behaviour:
- Reset (reset=0, asynchronous), all outputs cleared immediately:
  - o_rd_en=0, o_col=0, o_col_valid=0, o_eol=0, o_top=0.
  - Column counter=0, state=IDLE.
- pop_ok = i_enable && (i_empty == 0). A pop requires every FIFO to be non-empty; a partial pop never occurs.
- States:
  - IDLE: o_rd_en = {N_LINES{pop_ok}} (combinational from registered state and inputs). If pop_ok → POP.
  - POP: the cycle after the read strobe, i_dout is valid. Register o_col slot j ← FIFO (o_top + j) mod N_LINES. Set o_col_valid=1 and o_eol = (col_cnt == IMG_WIDTH-1). → HOLD.
  - HOLD: o_col, o_col_valid and o_eol are held stable until i_col_ready=1.
- On handshake (o_col_valid && i_col_ready):
  - If o_eol: col_cnt←0 and o_top←(o_top+1) mod N_LINES; o_top wraps N_LINES-1→0.
  - Otherwise col_cnt←col_cnt+1.
  - In the same cycle: if pop_ok, o_rd_en is asserted and the state goes to POP (back-to-back). Otherwise the state goes to IDLE, o_col_valid drops next cycle, and o_col keeps its last value.
- Throughput and latency:
  - Throughput: one column per 2 cycles with ready held high.
  - Latency from rd_en to o_col_valid: 1 cycle.
- o_rd_en is never asserted in POP, or in HOLD without a handshake. This prevents overrun of the capture register.
- If i_empty bits rise after a pop, the pop still completes; the data was already requested.
- If i_enable falls mid-transfer, the column in flight is still presented and held. Only new pops are blocked.
- If reset asserts mid-transfer, the column is discarded and FIFOs are not re-read. Upstream is responsible for flushing the FIFOs on the same reset.
- o_top changes only on an eol handshake; it is never changed mid-line.

Optional Feature:
- Macro: LB_RD_LINECNT_EN.
- Defined:
  - Adds output o_line_cnt [15:0], reset to 0.
  - Increments on every eol handshake and wraps 16'hFFFF→0.
  - Adds a sticky output o_stall_err, reset to 0. It is set if o_col_valid stays high without ready for more than IMG_WIDTH consecutive cycles, and is cleared only by reset.
- Undefined: neither port exists, no counters are synthesized, and the rest of the behaviour is identical.

Test Plan:
- Reset check: assert reset=0 mid-POP with i_empty=0 → o_rd_en, o_col_valid, o_eol and o_top drop to 0 in the same cycle, with no clock edge needed.
- Single column: o_top=0, FIFO k data = 8'h10+k, empty=0, ready=1 → one-cycle o_rd_en=7'h7F, then o_col slots 0..6 = 10,11,…,16 with valid=1; the next o_rd_en comes on the handshake cycle.
- Partial empty: i_empty=7'b0000100 → o_rd_en stays 0 and valid stays 0 indefinitely; clear the bit → pop occurs on the next cycle.
- Backpressure: ready=0 for 20 cycles after valid → o_col stable, o_rd_en=0 throughout; ready=1 → handshake, then the next pop.
- End of line and rotation (IMG_WIDTH=4): stream 4 columns → o_eol=1 only on the 4th, then o_top=1 and FIFO 1 maps to slot 0. After 7 lines, o_top wraps to 0.
- Feature on (LB_RD_LINECNT_EN): 3 lines at IMG_WIDTH=4 → o_line_cnt=3. Hold ready=0 for 5 cycles → o_stall_err=1 and stays set after ready returns.

Source files
------------

// File: rtl/line_buffer_reader.sv
// line_buffer_reader: pops all line FIFOs together and presents an ordered pixel column.
// Latency: read strobe to o_col_valid is one cycle (capture cycle); one column per 2 cycles.
// Backpressure: the column is held while i_col_ready is low, and no new read strobe is issued.
//
// Ports:
//   i_clk, reset        clock and asynchronous active-low reset
//   i_enable, i_empty   pop qualifiers: all FIFOs non-empty and enable high
//   i_dout              FIFO read data, FIFO k at [k*D_BITS +: D_BITS], valid 1 cycle after o_rd_en
//   o_rd_en             read strobe to every line FIFO (all bits equal)
//   o_col, o_col_valid, i_col_ready, o_eol
//                       column to the window stage, slot 0 = oldest line; o_eol marks last column of line
//   o_top               FIFO index currently mapped to slot 0
// Optional feature macro LB_RD_LINECNT_EN adds o_line_cnt (completed lines) and o_stall_err
// (sticky: column held without ready for more than IMG_WIDTH consecutive cycles).
module line_buffer_reader #(
  parameter int D_BITS    = 8,
  parameter int N_LINES   = 7,
  parameter int IMG_WIDTH = 640,
  parameter int COL_W     = $clog2(IMG_WIDTH)
) (
  input  logic                       i_clk,
  input  logic                       reset,
  input  logic                       i_enable,
  input  logic [N_LINES-1:0]         i_empty,
  input  logic [N_LINES*D_BITS-1:0]  i_dout,
  output logic [N_LINES-1:0]         o_rd_en,
  output logic [N_LINES*D_BITS-1:0]  o_col,
  output logic                       o_col_valid,
  input  logic                       i_col_ready,
  output logic                       o_eol,
  output logic [$clog2(N_LINES)-1:0] o_top
`ifdef LB_RD_LINECNT_EN
  ,
  output logic [15:0]                o_line_cnt,
  output logic                       o_stall_err
`endif
);

  localparam int TOP_W = $clog2(N_LINES);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [TOP_W-1:0] LAST_TOP = TOP_W'(N_LINES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                      state;
  logic [COL_W-1:0]            col_cnt;
  logic                        pop_ok;
  logic                        handshake;
  logic                        rd_req;
  logic [TOP_W-1:0]            next_top;
  logic [N_LINES*D_BITS-1:0]   cap_col;

  // A pop needs every FIFO non-empty so the column is never torn.
  assign pop_ok    = i_enable && (i_empty == '0);
  assign handshake = o_col_valid && i_col_ready;

  // Reads are issued from IDLE, or from HOLD only in the cycle the held
  // column leaves; never from POP, so the capture register cannot be overrun.
  always_comb begin
    rd_req = 1'b0;
    case (state)
      IDLE:    rd_req = pop_ok;
      HOLD:    rd_req = handshake && pop_ok;
      default: rd_req = 1'b0;
    endcase
  end

  // Gated by reset so the strobe drops immediately when reset asserts.
  assign o_rd_en = {N_LINES{rd_req & reset}};

  assign next_top = (o_top == LAST_TOP) ? '0 : o_top + 1'b1;

  // Rotate FIFO outputs so slot j carries FIFO (o_top + j) mod N_LINES.
  always_comb begin
    cap_col = '0;
    for (int j = 0; j < N_LINES; j++) begin
      cap_col[j*D_BITS +: D_BITS] = i_dout[((int'(o_top) + j) % N_LINES)*D_BITS +: D_BITS];
    end
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      col_cnt     <= '0;
      o_col       <= '0;
      o_col_valid <= 1'b0;
      o_eol       <= 1'b0;
      o_top       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop_ok) state <= POP;
        end
        POP: begin
          // FIFO data requested last cycle is on i_dout now.
          o_col       <= cap_col;
          o_col_valid <= 1'b1;
          o_eol       <= (col_cnt == LAST_COL);
          state       <= HOLD;
        end
        HOLD: begin
          if (i_col_ready) begin
            o_col_valid <= 1'b0;
            o_eol       <= 1'b0;
            if (o_eol) begin
              col_cnt <= '0;
              o_top   <= next_top;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
            state <= pop_ok ? POP : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LB_RD_LINECNT_EN
  localparam int STALL_W = $clog2(IMG_WIDTH + 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(IMG_WIDTH);

  logic [STALL_W-1:0] stall_cnt;

  // stall_cnt counts preceding stalled cycles; a stalled cycle seen with
  // stall_cnt == IMG_WIDTH is the first one beyond the allowed window.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      o_line_cnt  <= '0;
      o_stall_err <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (handshake && o_eol) o_line_cnt <= o_line_cnt + 16'd1;
      if (o_col_valid && !i_col_ready) begin
        if (stall_cnt == STALL_LIM) o_stall_err <= 1'b1;
        else                        stall_cnt   <= stall_cnt + 1'b1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end
`endif

endmodule
